// File: rtl/imm_gen_pipe.sv
// Registered, flow-controlled immediate generator for the decode stage.
// Decodes {instr, imm_sel} into an XLEN-wide immediate, returns it one cycle
// after acceptance together with its tag, and uses a one-entry skid buffer so
// that in_ready never depends combinationally on out_ready.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // Opcode bits never contribute to any immediate format.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_ill_q,   main_ill_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_ill_q,   skid_ill_d;

  logic             accept;
  logic             fire;

  // Immediate decode; signed casts replicate the format's top bit up to XLEN.
  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    case (in_imm_sel)
      3'd0: dec_imm = XLEN'($signed(in_instr[31:20]));
      3'd1: dec_imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
      3'd2: dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      3'd3: dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
      3'd4: dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      3'd5: dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
      3'd6: dec_imm = XLEN'(in_instr[19:15]);
      default: dec_ill = 1'b1;
    endcase
  end

  // in_ready comes only from the skid flop (and reset), never from out_ready.
  assign in_ready  = ~skid_valid_q & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = main_valid_q;
  assign fire      = main_valid_q & out_ready;

  // Next-state for main and skid entries in priority order: flush, skid
  // refill, direct load, skid load, drain.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (fire && skid_valid_q) begin
      main_valid_d = 1'b1;
      main_imm_d   = skid_imm_q;
      main_tag_d   = skid_tag_q;
      main_ill_d   = skid_ill_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || fire)) begin
      main_valid_d = 1'b1;
      main_imm_d   = dec_imm;
      main_tag_d   = in_tag;
      main_ill_d   = dec_ill;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_tag_d   = in_tag;
      skid_ill_d   = dec_ill;
    end else if (fire) begin
      main_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset clearing valids and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_imm     = main_imm_q;
  assign out_tag     = main_tag_q;
  assign out_illegal = main_ill_q;

endmodule
